// File: rtl/sd_responder_if.sv
// SPI bus between an SD host (master) and the sd_responder card model (slave).
interface sd_responder_if;
    logic SPI_CS;
    logic SPI_SCLK;
    logic SPI_MOSI;
    logic SPI_MISO;

    modport master (output SPI_CS, output SPI_SCLK, output SPI_MOSI, input SPI_MISO);
    modport slave  (input SPI_CS, input SPI_SCLK, input SPI_MOSI, output SPI_MISO);
endinterface

// File: rtl/sd_responder.sv
// SD card SPI-mode responder: command capture, R1 replies and single-block reads.
// Macro SD_RESPONDER_CRC16_EN builds a CRC-16-CCITT over read data; otherwise CRC bytes are FF FF.
module sd_responder (
    input  logic          clock,
    input  logic          reset,
    sd_responder_if.slave spi,
    output logic          cmd_valid,
    output logic [5:0]    cmd_index,
    output logic [31:0]   cmd_arg,
    output logic [8:0]    rd_addr,
    input  logic [7:0]    rd_data,
    output logic          busy
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CRC_W  = 16;
    localparam logic [5:0]  CMD_GO_IDLE = 6'd0;
    localparam logic [5:0]  CMD_READ    = 6'd17;
    localparam logic [5:0]  CMD_APP_OP  = 6'd41;
    localparam logic [5:0]  CMD_APP     = 6'd55;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_NCR, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC
    } state_t;

    state_t              state;
    logic [1:0]          cs_sync;
    logic [1:0]          sclk_sync;
    logic [1:0]          mosi_sync;
    logic                sclk_q;
    logic [2:0]          bit_cnt;
    logic [BYTE_W-2:0]   rx_sr;
    logic [BYTE_W-1:0]   tx_sr;
    logic [BYTE_W-1:0]   tx_next;
    logic [BYTE_W-1:0]   rx_byte;
    logic [BYTE_W-1:0]   r1_c;
    logic [BYTE_W-1:0]   r1_q;
    logic [2:0]          byte_cnt;
    logic [5:0]          frame_idx;
    logic [31:0]         frame_arg;
    logic                is_read;
    logic                idle_flag;
    logic                app_flag;
    logic                armed;
    logic [1:0]          settle;
    logic                crc_second;
    logic [CRC_W-1:0]    data_crc;
    logic                cs_high;
    logic                sclk_rise;
    logic                sclk_fall;
    logic                byte_done;

    assign spi.SPI_MISO = tx_sr[BYTE_W-1];
    assign cs_high      = cs_sync[1];
    assign sclk_rise    = sclk_sync[1] & ~sclk_q;
    assign sclk_fall    = ~sclk_sync[1] & sclk_q;
    assign rx_byte      = {rx_sr, mosi_sync[1]};
    assign byte_done    = ~cs_high & sclk_rise & (bit_cnt == 3'd7) & armed;

`ifdef SD_RESPONDER_CRC16_EN
    logic [CRC_W-1:0] crc;
    logic [CRC_W-1:0] crc_upd;
    logic             load_data;

    assign load_data = (state == S_TOKEN) || ((state == S_DATA) && (rd_addr != '0));
    assign data_crc  = crc;

    // Byte-at-a-time CRC-16-CCITT (poly 0x1021), MSB first.
    always_comb begin
        crc_upd = crc ^ {rd_data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            crc_upd = crc_upd[15] ? ((crc_upd << 1) ^ 16'h1021) : (crc_upd << 1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            crc <= '0;
        end else if (byte_done) begin
            if (state == S_R1) begin
                crc <= '0;
            end else if (load_data) begin
                crc <= crc_upd;
            end
        end
    end
`else
    assign data_crc = 16'hFFFF;
`endif

    // R1 response for the frame just captured.
    always_comb begin
        r1_c = 8'h04 | {7'b0, idle_flag};
        if (frame_idx == CMD_GO_IDLE) begin
            r1_c = 8'h01;
        end else if (frame_idx == CMD_APP) begin
            r1_c = {7'b0, idle_flag};
        end else if ((frame_idx == CMD_APP_OP) && app_flag) begin
            r1_c = 8'h00;
        end else if (frame_idx == CMD_READ) begin
            r1_c = 8'h00;
        end
    end

    // Byte to present during the byte period that starts at this completion.
    always_comb begin
        tx_next = 8'hFF;
        case (state)
            S_NCR:   tx_next = r1_q;
            S_GAP:   tx_next = 8'hFE;
            S_TOKEN: tx_next = rd_data;
            S_DATA:  tx_next = (rd_addr == '0) ? data_crc[15:8] : rd_data;
            S_CRC:   tx_next = crc_second ? 8'hFF : data_crc[7:0];
            default: tx_next = 8'hFF;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cs_sync    <= 2'b11;
            sclk_sync  <= 2'b00;
            mosi_sync  <= 2'b11;
            sclk_q     <= 1'b0;
            state      <= S_IDLE;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= 8'hFF;
            byte_cnt   <= '0;
            frame_idx  <= '0;
            frame_arg  <= '0;
            r1_q       <= 8'hFF;
            is_read    <= 1'b0;
            idle_flag  <= 1'b1;
            app_flag   <= 1'b0;
            armed      <= 1'b0;
            settle     <= '0;
            crc_second <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_index  <= '0;
            cmd_arg    <= '0;
            rd_addr    <= '0;
            busy       <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], spi.SPI_CS};
            sclk_sync <= {sclk_sync[0], spi.SPI_SCLK};
            mosi_sync <= {mosi_sync[0], spi.SPI_MOSI};
            sclk_q    <= sclk_sync[1];
            cmd_valid <= 1'b0;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end

            // Only a CS-high seen after the synchronizers hold real samples re-aligns the byte framing.
            if (cs_high) begin
                if (settle == 2'd2) begin
                    armed <= 1'b1;
                end
                state   <= S_IDLE;
                bit_cnt <= '0;
                tx_sr   <= 8'hFF;
                busy    <= 1'b0;
            end else if (sclk_rise) begin
                rx_sr   <= rx_byte[BYTE_W-2:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    armed <= 1'b1;
                end
                if (byte_done) begin
                    tx_sr <= tx_next;
                    case (state)
                        S_IDLE: begin
                            if (rx_byte[7:6] == 2'b01) begin
                                frame_idx <= rx_byte[5:0];
                                byte_cnt  <= 3'd1;
                                state     <= S_CMD;
                            end
                        end
                        S_CMD: begin
                            if (byte_cnt != 3'd5) begin
                                frame_arg <= {frame_arg[23:0], rx_byte};
                                byte_cnt  <= byte_cnt + 3'd1;
                            end else begin
                                cmd_valid <= 1'b1;
                                cmd_index <= frame_idx;
                                cmd_arg   <= frame_arg;
                                r1_q      <= r1_c;
                                busy      <= 1'b1;
                                is_read   <= (frame_idx == CMD_READ);
                                app_flag  <= (frame_idx == CMD_APP);
                                if (frame_idx == CMD_GO_IDLE) begin
                                    idle_flag <= 1'b1;
                                end else if ((frame_idx == CMD_APP_OP) && app_flag) begin
                                    idle_flag <= 1'b0;
                                end
                                state <= S_NCR;
                            end
                        end
                        S_NCR: state <= S_R1;
                        S_R1: begin
                            if (is_read) begin
                                rd_addr <= '0;
                                state   <= S_GAP;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                        S_GAP: state <= S_TOKEN;
                        S_TOKEN: begin
                            rd_addr <= rd_addr + 9'd1;
                            state   <= S_DATA;
                        end
                        // rd_addr wraps to 0 after byte 511 is loaded, marking the end of the block.
                        S_DATA: begin
                            if (rd_addr == '0) begin
                                crc_second <= 1'b0;
                                state      <= S_CRC;
                            end else begin
                                rd_addr <= rd_addr + 9'd1;
                            end
                        end
                        S_CRC: begin
                            if (!crc_second) begin
                                crc_second <= 1'b1;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end else if (sclk_fall && (bit_cnt != 3'd0)) begin
                // The falling edge right after a byte completes keeps the freshly loaded MSB.
                tx_sr <= {tx_sr[BYTE_W-2:0], 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_sd_responder.sv
// Self-checking bench for sd_responder: table of commands, full/aborted block reads, reset cases, random commands.
module tb_sd_responder;
    localparam int HALF = 50;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [7:0]  r1;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [8:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   cv_count = 0;
    logic m_idle;
    logic m_app;
    vec_t tbl [11];
    logic [5:0] pool [7];

    sd_responder_if spi ();

    sd_responder dut (
        .clock     (clock),
        .reset     (reset),
        .spi       (spi),
        .cmd_valid (cmd_valid),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rd_data <= rd_addr[7:0];

    always @(negedge clock) if (cmd_valid === 1'b1) cv_count <= cv_count + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the test finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Spec-level R1 rules and card flags.
    task automatic model_cmd(input logic [5:0] idx, output logic [7:0] r1);
        if (idx == 6'd0) begin
            r1 = 8'h01;
            m_idle = 1'b1;
        end else if (idx == 6'd55) begin
            r1 = {7'b0, m_idle};
        end else if (idx == 6'd41 && m_app) begin
            r1 = 8'h00;
            m_idle = 1'b0;
        end else if (idx == 6'd17) begin
            r1 = 8'h00;
        end else begin
            r1 = 8'h04 | {7'b0, m_idle};
        end
        m_app = (idx == 6'd55);
    endtask

`ifdef SD_RESPONDER_CRC16_EN
    function automatic logic [15:0] crc_ref();
        logic [15:0] c;
        logic [7:0]  d;
        logic        fb;
        c = 16'h0000;
        for (int n = 0; n < 512; n++) begin
            d = 8'(n);
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ d[b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction
`endif

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi.SPI_MOSI = tx[i];
            #(HALF);
            rx[i] = spi.SPI_MISO;
            spi.SPI_SCLK = 1'b1;
            #(HALF);
            spi.SPI_SCLK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, output logic all_ff);
        logic [7:0] fr [6];
        logic [7:0] b;
        fr[0] = {2'b01, idx};
        fr[1] = arg[31:24];
        fr[2] = arg[23:16];
        fr[3] = arg[15:8];
        fr[4] = arg[7:0];
        fr[5] = (idx == 6'd0) ? 8'h95 : 8'h01;
        all_ff = 1'b1;
        for (int i = 0; i < 6; i++) begin
            xfer(fr[i], b);
            if (b !== 8'hFF) all_ff = 1'b0;
        end
    endtask

    task automatic frame_checks(input logic [5:0] idx, input logic [31:0] arg);
        int         cv0;
        logic       ok;
        logic [7:0] b;
        cv0 = cv_count;
        send_frame(idx, arg, ok);
        chk("frame_miso_ff", 32'(ok), 32'd1);
        chk("cmd_valid_pulses", 32'(cv_count - cv0), 32'd1);
        chk("cmd_index", 32'(cmd_index), 32'(idx));
        chk("cmd_arg", cmd_arg, arg);
        chk("busy_after_frame", 32'(busy), 32'd1);
        xfer(8'hFF, b);
        chk("ncr_byte", 32'(b), 32'h000000FF);
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] r1_exp);
        logic [7:0] b;
        frame_checks(idx, arg);
        xfer(8'hFF, b);
        chk($sformatf("r1_cmd%0d", idx), 32'(b), 32'(r1_exp));
        chk("busy_after_r1", 32'(busy), 32'd0);
        xfer(8'hFF, b);
        chk("idle_after_r1", 32'(b), 32'h000000FF);
    endtask

    task automatic read_head();
        logic [7:0] b;
        logic [7:0] r;
        model_cmd(6'd17, r);
        frame_checks(6'd17, 32'h00000200);
        xfer(8'hFF, b);
        chk("r1_cmd17", 32'(b), 32'(r));
        chk("busy_after_r1_read", 32'(busy), 32'd1);
        xfer(8'hFF, b);
        chk("gap_byte", 32'(b), 32'h000000FF);
        xfer(8'hFF, b);
        chk("token_byte", 32'(b), 32'h000000FE);
    endtask

    initial begin
        logic [7:0]  b;
        logic [7:0]  r;
        logic [15:0] exp_crc;
        logic [31:0] arg;
        logic [5:0]  idx;
        logic        ok;
        int          cv0;

        reset = 1'b1;
        spi.SPI_CS = 1'b1;
        spi.SPI_SCLK = 1'b0;
        spi.SPI_MOSI = 1'b1;
        m_idle = 1'b1;
        m_app = 1'b0;
        pool = '{6'd0, 6'd9, 6'd55, 6'd41, 6'd8, 6'd58, 6'd13};

        tbl[0]  = '{idx: 6'd0,  arg: 32'h00000000, r1: 8'h01};
        tbl[1]  = '{idx: 6'd55, arg: 32'h00000000, r1: 8'h01};
        tbl[2]  = '{idx: 6'd41, arg: 32'h40000000, r1: 8'h00};
        tbl[3]  = '{idx: 6'd55, arg: 32'h00000000, r1: 8'h00};
        tbl[4]  = '{idx: 6'd9,  arg: 32'h00000000, r1: 8'h04};
        tbl[5]  = '{idx: 6'd41, arg: 32'h40000000, r1: 8'h04};
        tbl[6]  = '{idx: 6'd0,  arg: 32'h00000000, r1: 8'h01};
        tbl[7]  = '{idx: 6'd9,  arg: 32'h12345678, r1: 8'h05};
        tbl[8]  = '{idx: 6'd58, arg: 32'hABCDEF01, r1: 8'h05};
        tbl[9]  = '{idx: 6'd55, arg: 32'h00000000, r1: 8'h01};
        tbl[10] = '{idx: 6'd41, arg: 32'h40000000, r1: 8'h00};

        repeat (4) @(negedge clock);
        chk("reset_miso", 32'(spi.SPI_MISO), 32'd1);
        chk("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("reset_cmd_index", 32'(cmd_index), 32'd0);
        chk("reset_cmd_arg", cmd_arg, 32'd0);
        chk("reset_rd_addr", 32'(rd_addr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        #3;
        spi.SPI_CS = 1'b0;
        #100;

        // Command table: CMD0, ACMD41 init flow, unknown commands.
        for (int i = 0; i < 11; i++) begin
            model_cmd(tbl[i].idx, r);
            send_cmd(tbl[i].idx, tbl[i].arg, tbl[i].r1);
        end

        // Full 512-byte block read.
`ifdef SD_RESPONDER_CRC16_EN
        exp_crc = crc_ref();
`else
        exp_crc = 16'hFFFF;
`endif
        read_head();
        for (int i = 0; i < 512; i++) begin
            xfer(8'hFF, b);
            chk($sformatf("data_%0d", i), 32'(b), 32'(i & 255));
            if (i == 256) chk("busy_mid_data", 32'(busy), 32'd1);
        end
        xfer(8'hFF, b);
        chk("crc_hi", 32'(b), 32'(exp_crc[15:8]));
        chk("busy_before_crc_lo", 32'(busy), 32'd1);
        xfer(8'hFF, b);
        chk("crc_lo", 32'(b), 32'(exp_crc[7:0]));
        chk("busy_after_crc", 32'(busy), 32'd0);
        chk("rd_addr_end", 32'(rd_addr), 32'd0);
        chk("read_cmd_arg", cmd_arg, 32'h00000200);
        xfer(8'hFF, b);
        chk("idle_after_crc", 32'(b), 32'h000000FF);

        // Abort a read with CS high during data byte 100.
        read_head();
        for (int i = 0; i < 100; i++) begin
            xfer(8'hFF, b);
            chk($sformatf("abort_data_%0d", i), 32'(b), 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            spi.SPI_MOSI = 1'b1;
            #(HALF);
            spi.SPI_SCLK = 1'b1;
            #(HALF);
            spi.SPI_SCLK = 1'b0;
        end
        @(negedge clock);
        spi.SPI_CS = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_miso", 32'(spi.SPI_MISO), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clock);
        #3;
        spi.SPI_CS = 1'b0;
        #100;
        model_cmd(6'd0, r);
        send_cmd(6'd0, 32'h0, r);

        // Reset in the middle of a frame with CS held low.
        model_cmd(6'd58, r);
        send_cmd(6'd58, 32'hA5A5A5A5, r);
        xfer(8'h49, b);
        xfer(8'h00, b);
        xfer(8'h00, b);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("midreset_cmd_index", 32'(cmd_index), 32'd0);
        chk("midreset_cmd_arg", cmd_arg, 32'd0);
        chk("midreset_miso", 32'(spi.SPI_MISO), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        m_idle = 1'b1;
        m_app = 1'b0;
        #3;
        #100;
        cv0 = cv_count;
        send_frame(6'd0, 32'h0, ok);
        chk("first_frame_after_reset_ignored", 32'(cv_count - cv0), 32'd0);
        model_cmd(6'd0, r);
        send_cmd(6'd0, 32'h0, r);

        // Random commands with junk idle bytes in between.
        for (int n = 0; n < 12; n++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = ($urandom_range(0, 1) == 0) ? 8'hFF : (8'h80 | 8'($urandom_range(0, 63)));
                xfer(b, b);
                chk("junk_idle_ff", 32'(b), 32'h000000FF);
            end
            idx = pool[$urandom_range(0, 6)];
            arg = $urandom;
            model_cmd(idx, r);
            send_cmd(idx, arg, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_responder.md
SD_RESPONDER -- requirements
Module: sd_responder

Interface
REQ-001 clock  in  1  system clock; all logic rises on posedge clock.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on posedge clock.
REQ-003 SPI_CS  in  1  chip select from SD host, active low, asynchronous to clock.
REQ-004 SPI_SCLK  in  1  SPI clock from host, mode 0 (CPOL=0, CPHA=0), asynchronous.
REQ-005 SPI_MOSI  in  1  host-to-card data, MSB first.
REQ-006 SPI_MISO  out  1  card-to-host data, MSB first; idles at 1.
REQ-007 cmd_valid  out  1  one-clock pulse when a complete 6-byte command frame is captured.
REQ-008 cmd_index  out  6  command index of the last frame, bits 5:0 of frame byte 0.
REQ-009 cmd_arg  out  32  argument of the last frame, bytes 1..4, big-endian.
REQ-010 rd_addr  out  9  byte offset within the 512-byte block being read.
REQ-011 rd_data  in  8  block byte at rd_addr; valid one clock after rd_addr changes.
REQ-012 busy  out  1  high from frame capture until the last response or CRC byte is shifted out.

Function
REQ-013 SPI_CS, SPI_SCLK and SPI_MOSI each pass through a 2-flop synchronizer; edges are detected on the synchronized SCLK.
REQ-014 Host SCLK high and low phases are each at least 4 clock periods; shorter phases are out of scope.
REQ-015 Synchronized SCLK rising edge: sample MOSI into rx shift register; increment 3-bit bit counter.
REQ-016 Synchronized SCLK falling edge: shift tx register left; drive SPI_MISO from tx bit 7.
REQ-017 At bit count wrap 7->0, the received byte completes and the next tx byte loads; its MSB drives SPI_MISO within 1 clock.
REQ-018 States: IDLE, CMD, NCR, R1, GAP, TOKEN, DATA, CRC.
REQ-019 IDLE: tx byte = 0xFF; a received byte with bits 7:6 = 01 stores byte 0 and enters CMD; any other byte is ignored.
REQ-020 CMD: capture bytes 1..5; byte 5 (CRC) is not checked; after byte 5, pulse cmd_valid, update cmd_index/cmd_arg, enter NCR.
REQ-021 NCR: transmit one 0xFF byte, then enter R1.
REQ-022 R1 value: CMD0 -> 0x01 and set idle flag; CMD55 -> {7'b0, idle}; ACMD41 (CMD41 directly after CMD55) -> 0x00 and clear idle; CMD17 -> 0x00; any other index -> 0x04 | idle.
REQ-023 After R1: CMD17 enters GAP; all other commands return to IDLE.
REQ-024 GAP: transmit one 0xFF byte, then TOKEN; TOKEN: transmit 0xFE, then DATA.
REQ-025 DATA: transmit 512 bytes rd_data[0..511]; rd_addr = 0 on entry to GAP, increments at each DATA byte load; increment after byte 511 wraps to 0.
REQ-026 CRC: transmit 2 bytes (REQ-033), then IDLE; busy falls when the second CRC byte load completes.
REQ-027 Command bytes received during NCR..CRC are ignored; no command nesting.
REQ-028 SPI_CS high (synchronized): state -> IDLE; bit counter = 0; tx = 0xFF; SPI_MISO = 1; busy = 0. Idle flag and CMD55 flag are unaffected.
REQ-029 CS fall mid-byte is not required; the bit counter starts at 0 on every CS fall.

Reset
REQ-030 On reset: state IDLE; SPI_MISO=1; cmd_valid=0; cmd_index=0; cmd_arg=0; rd_addr=0; busy=0; idle flag=1; CMD55 flag=0; synchronizers=CS 1, SCLK 0, MOSI 1.
REQ-031 Reset in any state aborts the transfer; the first byte completion after reset is ignored unless CS has been high.

Configuration
REQ-032 The macro SD_RESPONDER_CRC16_EN selects the data CRC.
REQ-033 SD_RESPONDER_CRC16_EN defined: CRC is the CRC-16-CCITT (poly 0x1021, init 0x0000) of the 512 data bytes, sent MSB byte first. Undefined: CRC bytes are 0xFF, 0xFF and no CRC logic is built.

Verification
REQ-034 Reset, CS low, send 40 00 00 00 00 95 -> cmd_valid pulse, cmd_index=0, cmd_arg=0; MISO bytes after the frame are FF, 01, FF.
REQ-035 Send CMD55 then CMD41 (arg 0x40000000) -> R1 = 01 then 00; a following CMD55 -> R1 00.
REQ-036 After init, send CMD17 arg 0x00000200, rd_data = rd_addr[7:0] -> MISO FF, 00, FF, FE, 00..FF twice, CRC; cmd_arg=0x200; rd_addr ends at 0.
REQ-037 Same block with CRC16_EN -> CRC bytes match the reference CRC-16 of pattern; without the macro -> FF FF.
REQ-038 Deassert CS at data byte 100 -> MISO=1 within 3 clocks, busy=0; next CMD0 responds normally with 01.
REQ-039 Send CMD9 -> R1 = 0x04 | idle; state returns to IDLE; busy low after the R1 byte.
